// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 1-D pooling stage: mode encodings and
// elaboration-time sizing helpers.
package pool_pkg;

   localparam int MODE_MAX = 0;
   localparam int MODE_AVG = 1;

   // Ceiling log2; clog2(1) == 0 so a unit kernel needs no averaging shift.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res++;
         rem = rem >> 1;
      end
      return res;
   endfunction

   function automatic int n_out(input int seq_len, input int kernel, input int stride);
      return (seq_len - kernel) / stride + 1;
   endfunction

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int width_of(input int max_val);
      return (clog2(max_val + 1) > 0) ? clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/pool_reduce.sv
// Combinational per-channel reduction over KERNEL values: max, or floor
// average for power-of-two kernels.
module pool_reduce
   import pool_pkg::*;
#(
   parameter int KERNEL     = 2,
   parameter int ACTIV_BITS = 16,
   parameter int MODE       = MODE_MAX,
   parameter int SIGNED     = 1
) (
   input  logic [KERNEL*ACTIV_BITS-1:0] vals,
   output logic [ACTIV_BITS-1:0]        result
);

   localparam int LOG2K = clog2(KERNEL);
   localparam int SUM_W = ACTIV_BITS + LOG2K;

   function automatic logic [SUM_W-1:0] extend(input logic [ACTIV_BITS-1:0] v);
      logic [SUM_W-1:0] e;
      e = {SUM_W{(SIGNED != 0) && v[ACTIV_BITS-1]}};
      e[ACTIV_BITS-1:0] = v;
      return e;
   endfunction

   function automatic logic greater(input logic [ACTIV_BITS-1:0] a, input logic [ACTIV_BITS-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   generate
      if (MODE == MODE_AVG) begin : g_avg
         logic [SUM_W-1:0] sum;

         always_comb begin
            sum = '0;
            for (int i = 0; i < KERNEL; i++) sum = sum + extend(vals[i*ACTIV_BITS +: ACTIV_BITS]);
         end

         // Dropping the low LOG2K bits of the sign-extended sum is the
         // arithmetic right shift, i.e. rounding toward minus infinity.
         assign result = sum[SUM_W-1:LOG2K];

         if (LOG2K > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^sum[LOG2K-1:0];
         end
      end else begin : g_max
         logic [ACTIV_BITS-1:0] best;

         always_comb begin
            best = vals[ACTIV_BITS-1:0];
            for (int i = 1; i < KERNEL; i++) begin
               if (greater(vals[i*ACTIV_BITS +: ACTIV_BITS], best)) best = vals[i*ACTIV_BITS +: ACTIV_BITS];
            end
         end

         assign result = best;
      end
   endgenerate

endmodule

// File: rtl/pool1d_stream.sv
// Streaming 1-D pooling along the time axis: sliding window of past frames,
// frame/phase/emission counters and a single-entry valid/ready output register.
module pool1d_stream
   import pool_pkg::*;
#(
   parameter int CHANNELS   = 8,
   parameter int ACTIV_BITS = 16,
   parameter int KERNEL     = 2,
   parameter int STRIDE     = 2,
   parameter int SEQ_LEN    = 40,
   parameter int MODE       = MODE_MAX,
   parameter int SIGNED     = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic [CHANNELS*ACTIV_BITS-1:0] in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [CHANNELS*ACTIV_BITS-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last
);

   localparam int FRAME_W = CHANNELS * ACTIV_BITS;
   localparam int N_OUT   = n_out(SEQ_LEN, KERNEL, STRIDE);
   localparam int CNT_W   = width_of(SEQ_LEN - 1);
   localparam int PH_W    = width_of(STRIDE - 1);
   localparam int IDX_W   = width_of(N_OUT - 1);

   logic [CNT_W-1:0]   frame_cnt;
   logic [PH_W-1:0]    phase;
   logic [IDX_W-1:0]   out_idx;
   logic               accept;
   logic               window_full;
   logic               emit;
   logic               last_frame;
   logic               is_last;
   logic [FRAME_W-1:0] frames [KERNEL];
   logic [FRAME_W-1:0] pooled;

   assign in_ready    = !out_valid || out_ready;
   assign accept      = in_valid && in_ready && !clear;
   assign window_full = frame_cnt >= CNT_W'(KERNEL - 1);
   assign emit        = window_full && (phase == '0);
   assign last_frame  = frame_cnt == CNT_W'(SEQ_LEN - 1);
   assign is_last     = out_idx == IDX_W'(N_OUT - 1);

   // Window history is never cleared on wrap or clear: emission waits for
   // KERNEL-1 fresh frames, by which point every stale entry has shifted out.
   generate
      if (KERNEL > 1) begin : g_win
         logic [FRAME_W-1:0] hist [KERNEL-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int j = 0; j < KERNEL - 1; j++) hist[j] <= '0;
            end else if (accept) begin
               for (int j = KERNEL - 2; j > 0; j--) hist[j] <= hist[j-1];
               hist[0] <= in_data;
            end
         end

         always_comb begin
            frames[0] = in_data;
            for (int j = 1; j < KERNEL; j++) frames[j] = hist[j-1];
         end
      end else begin : g_nowin
         always_comb frames[0] = in_data;
      end
   endgenerate

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic [KERNEL*ACTIV_BITS-1:0] vals;

         always_comb begin
            vals = '0;
            for (int j = 0; j < KERNEL; j++) vals[j*ACTIV_BITS +: ACTIV_BITS] = frames[j][c*ACTIV_BITS +: ACTIV_BITS];
         end

         pool_reduce #(
            .KERNEL     (KERNEL),
            .ACTIV_BITS (ACTIV_BITS),
            .MODE       (MODE),
            .SIGNED     (SIGNED)
         ) u_reduce (
            .vals   (vals),
            .result (pooled[c*ACTIV_BITS +: ACTIV_BITS])
         );
      end
   endgenerate

   // phase is a down-counter: zero marks an emitting frame, then it reloads
   // to STRIDE-1 so the next emission lands exactly STRIDE frames later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase     <= '0;
         out_idx   <= '0;
      end else if (clear) begin
         frame_cnt <= '0;
         phase     <= '0;
         out_idx   <= '0;
      end else if (accept) begin
         if (last_frame) begin
            frame_cnt <= '0;
            phase     <= '0;
            out_idx   <= '0;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (window_full) phase <= (phase == '0) ? PH_W'(STRIDE - 1) : phase - 1'b1;
            if (emit && !is_last) out_idx <= out_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept && emit) begin
         out_valid <= 1'b1;
         out_last  <= is_last;
         out_data  <= pooled;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule
